// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types for the 6502 multi-cycle control FSM: states, addressing modes,
// ALU ops, register ids, datapath mux selects and the per-cycle strobe bundle.
package cpu_ctrl_fsm_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned MODE_W  = 4;
    localparam int unsigned ALU_W   = 4;

    // Cycles per instruction class with the memory port always ready
    localparam int unsigned CTRL_CYCLES_IMPLIED   = 2;
    localparam int unsigned CTRL_CYCLES_IMMEDIATE = 2;
    localparam int unsigned CTRL_CYCLES_ZERO_PAGE = 3;
    localparam int unsigned CTRL_CYCLES_ABSOLUTE  = 4;
    localparam int unsigned CTRL_CYCLES_INDIRECT  = 5;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 3'd0,
        EX_FOP1 = 3'd1,
        FOP2    = 3'd2,
        EX_IND  = 3'd3,
        EX_ABS  = 3'd4
    } ctrl_state_t;

    typedef enum logic [MODE_W-1:0] {
        IMPLIED           = 4'd0,
        ACCUMULATOR       = 4'd1,
        IMMEDIATE         = 4'd2,
        RELATIVE          = 4'd3,
        ZERO_PAGE         = 4'd4,
        ZERO_PAGE_X       = 4'd5,
        ZERO_PAGE_Y       = 4'd6,
        ABSOLUTE          = 4'd7,
        ABSOLUTE_X        = 4'd8,
        ABSOLUTE_Y        = 4'd9,
        INDIRECT_X        = 4'd10,
        INDIRECT_Y        = 4'd11,
        ABSOLUTE_INDIRECT = 4'd12
    } addressing_mode_t;

    typedef enum logic [ALU_W-1:0] {
        ALU_NOP          = 4'd0,
        ALU_ADD          = 4'd1,
        ALU_ADD_ZEROPAGE = 4'd2,
        ALU_SUB          = 4'd3,
        ALU_AND          = 4'd4,
        ALU_OR           = 4'd5,
        ALU_EOR          = 4'd6,
        ALU_PASS_B       = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        A_REG  = 2'd0,
        X_REG  = 2'd1,
        Y_REG  = 2'd2,
        SP_REG = 2'd3
    } reg_id_t;

    typedef enum logic {
        PC_FETCH_ADDRESS = 1'b0,
        ALU_ADDRESS      = 1'b1
    } ctrl_mux_mem_addr_t;

    typedef enum logic {
        FROM_DECODER = 1'b0,
        FROM_CTRL    = 1'b1
    } ctrl_mux_dec_ctrl_t;

    typedef enum logic [2:0] {
        REG_A_SRC            = 3'd0,
        IMMEDIATE_SRC        = 3'd1,
        DATA_FROM_MEMORY_SRC = 3'd2,
        OPERAND_SRC          = 3'd3,
        PTR_ADDR_SRC         = 3'd4
    } ctrl_mux_A_t;

    typedef enum logic [1:0] {
        ZERO_SRC    = 2'd0,
        IDX_REG_SRC = 2'd1,
        ONE_SRC     = 2'd2
    } ctrl_mux_B_t;

    typedef struct packed {
        logic ir_load;
        logic pc_inc;
        logic op1_load;
        logic op2_load;
        logic ptr_lo_load;
        logic reg_we;
        logic mem_we;
        logic done;
        logic illegal;
    } ctrl_strobe_t;

    function automatic logic is_zero_page(input addressing_mode_t m);
        return (m == ZERO_PAGE) || (m == ZERO_PAGE_X) || (m == ZERO_PAGE_Y);
    endfunction

    function automatic logic is_absolute(input addressing_mode_t m);
        return (m == ABSOLUTE) || (m == ABSOLUTE_X) || (m == ABSOLUTE_Y);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the FSM (master) and the decoder/datapath (slave).
interface cpu_ctrl_fsm_if;
    import cpu_ctrl_fsm_pkg::*;

    logic               mem_rdy_i;
    addressing_mode_t   dec_mode_i;
    logic               dec_is_store_i;
    logic               dec_reg_we_i;

    ctrl_state_t        state_o;
    logic               ir_load_o;
    logic               pc_inc_o;
    logic               op1_load_o;
    logic               op2_load_o;
    logic               ptr_lo_load_o;
    ctrl_mux_mem_addr_t mux_mem_addr_o;
    ctrl_mux_dec_ctrl_t mux_dec_ctrl_o;
    ctrl_mux_A_t        mux_A_o;
    ctrl_mux_B_t        mux_B_o;
    reg_id_t            idx_reg_o;
    alu_op_t            alu_op_ovr_o;
    logic               reg_we_o;
    logic               mem_we_o;
    logic               instr_done_o;
    logic               illegal_o;

    modport master (
        input  mem_rdy_i, dec_mode_i, dec_is_store_i, dec_reg_we_i,
        output state_o, ir_load_o, pc_inc_o, op1_load_o, op2_load_o, ptr_lo_load_o,
               mux_mem_addr_o, mux_dec_ctrl_o, mux_A_o, mux_B_o, idx_reg_o,
               alu_op_ovr_o, reg_we_o, mem_we_o, instr_done_o, illegal_o
    );

    modport slave (
        output mem_rdy_i, dec_mode_i, dec_is_store_i, dec_reg_we_i,
        input  state_o, ir_load_o, pc_inc_o, op1_load_o, op2_load_o, ptr_lo_load_o,
               mux_mem_addr_o, mux_dec_ctrl_o, mux_A_o, mux_B_o, idx_reg_o,
               alu_op_ovr_o, reg_we_o, mem_we_o, instr_done_o, illegal_o
    );

endinterface

// File: rtl/cpu_ctrl_fsm_addr_sel.sv
// Addressing mode -> index register, ALU B source and add flavour, for both the
// indirect pointer stage and the final effective-address stage.
module cpu_ctrl_addr_sel
    import cpu_ctrl_fsm_pkg::*;
(
    input  addressing_mode_t mode_i,
    input  logic             ptr_stage_i,
    output reg_id_t          idx_reg_c,
    output ctrl_mux_B_t      mux_b_c,
    output alu_op_t          alu_op_c
);

    always_comb begin
        idx_reg_c = A_REG;
        mux_b_c   = ZERO_SRC;
        alu_op_c  = ALU_ADD;
        if (ptr_stage_i) begin
            // Pointer lives in zero page: (zp + X) for (zp,X), plain zp for (zp),Y
            alu_op_c = ALU_ADD_ZEROPAGE;
            if (mode_i == INDIRECT_X) begin
                idx_reg_c = X_REG;
                mux_b_c   = IDX_REG_SRC;
            end
        end else begin
            case (mode_i)
                ZERO_PAGE_X, ABSOLUTE_X: begin
                    idx_reg_c = X_REG;
                    mux_b_c   = IDX_REG_SRC;
                end
                ZERO_PAGE_Y, ABSOLUTE_Y, INDIRECT_Y: begin
                    idx_reg_c = Y_REG;
                    mux_b_c   = IDX_REG_SRC;
                end
                default: ;
            endcase
            if (is_zero_page(mode_i)) begin
                alu_op_c = ALU_ADD_ZEROPAGE;
            end
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle 6502 control FSM: sequences fetch, operand fetch, address
// generation and execute over the shared memory port and ALU.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter bit MEM_STALL_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    cpu_ctrl_fsm_if.master bus
);

    ctrl_state_t        state_q, state_d, nxt;
    logic               rdy, bad_state;
    ctrl_strobe_t       stb, stb_g;
    ctrl_mux_mem_addr_t mux_mem;
    ctrl_mux_dec_ctrl_t mux_own;
    ctrl_mux_A_t        mux_a;
    ctrl_mux_B_t        mux_b;
    reg_id_t            idx_reg;
    alu_op_t            alu_op;

    reg_id_t            sel_idx;
    ctrl_mux_B_t        sel_b;
    alu_op_t            sel_alu;

    assign rdy = MEM_STALL_EN ? bus.mem_rdy_i : 1'b1;

    cpu_ctrl_addr_sel u_addr_sel (
        .mode_i      (bus.dec_mode_i),
        .ptr_stage_i (state_q == FOP2),
        .idx_reg_c   (sel_idx),
        .mux_b_c     (sel_b),
        .alu_op_c    (sel_alu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        nxt       = FETCH;
        bad_state = 1'b0;
        stb       = '0;
        mux_mem   = PC_FETCH_ADDRESS;
        mux_own   = FROM_DECODER;
        mux_a     = REG_A_SRC;
        mux_b     = ZERO_SRC;
        idx_reg   = A_REG;
        alu_op    = ALU_NOP;

        if (!rst_i) begin
            case (state_q)
                FETCH: begin
                    stb.ir_load = 1'b1;
                    stb.pc_inc  = 1'b1;
                    nxt         = EX_FOP1;
                end
                EX_FOP1: begin
                    case (bus.dec_mode_i)
                        IMPLIED, ACCUMULATOR: begin
                            stb.reg_we = bus.dec_reg_we_i;
                            stb.done   = 1'b1;
                        end
                        IMMEDIATE, RELATIVE: begin
                            stb.pc_inc = 1'b1;
                            mux_a      = IMMEDIATE_SRC;
                            stb.reg_we = bus.dec_reg_we_i;
                            stb.done   = 1'b1;
                        end
                        ZERO_PAGE, ZERO_PAGE_X, ZERO_PAGE_Y: begin
                            stb.op1_load = 1'b1;
                            stb.pc_inc   = 1'b1;
                            nxt          = EX_ABS;
                        end
                        ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y, INDIRECT_X, INDIRECT_Y: begin
                            stb.op1_load = 1'b1;
                            stb.pc_inc   = 1'b1;
                            nxt          = FOP2;
                        end
                        default: begin
                            stb.illegal = 1'b1;
                            stb.done    = 1'b1;
                        end
                    endcase
                end
                FOP2: begin
                    if (is_absolute(bus.dec_mode_i)) begin
                        stb.op2_load = 1'b1;
                        stb.pc_inc   = 1'b1;
                        nxt          = EX_ABS;
                    end else if (bus.dec_mode_i == INDIRECT_X ||
                                 bus.dec_mode_i == INDIRECT_Y) begin
                        mux_own         = FROM_CTRL;
                        mux_mem         = ALU_ADDRESS;
                        mux_a           = OPERAND_SRC;
                        mux_b           = sel_b;
                        idx_reg         = sel_idx;
                        alu_op          = sel_alu;
                        stb.ptr_lo_load = 1'b1;
                        nxt             = EX_IND;
                    end else begin
                        stb.illegal = 1'b1;
                        stb.done    = 1'b1;
                    end
                end
                EX_IND: begin
                    // Pointer high byte sits at the next zero-page location
                    mux_own      = FROM_CTRL;
                    mux_mem      = ALU_ADDRESS;
                    mux_a        = PTR_ADDR_SRC;
                    mux_b        = ONE_SRC;
                    alu_op       = ALU_ADD_ZEROPAGE;
                    stb.op2_load = 1'b1;
                    nxt          = EX_ABS;
                end
                EX_ABS: begin
                    mux_own  = FROM_CTRL;
                    mux_mem  = ALU_ADDRESS;
                    mux_b    = sel_b;
                    idx_reg  = sel_idx;
                    alu_op   = sel_alu;
                    stb.done = 1'b1;
                    if (bus.dec_is_store_i) begin
                        mux_a      = OPERAND_SRC;
                        stb.mem_we = 1'b1;
                    end else begin
                        mux_a      = DATA_FROM_MEMORY_SRC;
                        stb.reg_we = bus.dec_reg_we_i;
                    end
                end
                default: bad_state = 1'b1;
            endcase
        end

        stb_g = rdy ? stb : '0;

        if (rst_i || bad_state) state_d = FETCH;
        else if (rdy)           state_d = nxt;
        else                    state_d = state_q;
    end

    assign bus.state_o        = state_q;
    assign bus.ir_load_o      = stb_g.ir_load;
    assign bus.pc_inc_o       = stb_g.pc_inc;
    assign bus.op1_load_o     = stb_g.op1_load;
    assign bus.op2_load_o     = stb_g.op2_load;
    assign bus.ptr_lo_load_o  = stb_g.ptr_lo_load;
    assign bus.reg_we_o       = stb_g.reg_we;
    assign bus.mem_we_o       = stb_g.mem_we;
    assign bus.instr_done_o   = stb_g.done;
    assign bus.illegal_o      = stb_g.illegal;
    assign bus.mux_mem_addr_o = mux_mem;
    assign bus.mux_dec_ctrl_o = mux_own;
    assign bus.mux_A_o        = mux_a;
    assign bus.mux_B_o        = mux_b;
    assign bus.idx_reg_o      = idx_reg;
    assign bus.alu_op_ovr_o   = alu_op;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: each cycle queues the expected control word
// and checks it against the DUT mid-cycle.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_fsm_pkg::*;

    typedef struct {
        ctrl_state_t        st;
        ctrl_strobe_t       stb;
        ctrl_mux_mem_addr_t mem;
        ctrl_mux_dec_ctrl_t own;
        ctrl_mux_A_t        a;
        ctrl_mux_B_t        b;
        reg_id_t            idx;
        alu_op_t            alu;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   n_asserts = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t e;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(.MEM_STALL_EN(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input ctrl_state_t s);
        exp_t r;
        r.st  = s;
        r.stb = '0;
        r.mem = PC_FETCH_ADDRESS;
        r.own = FROM_DECODER;
        r.a   = REG_A_SRC;
        r.b   = ZERO_SRC;
        r.idx = A_REG;
        r.alu = ALU_NOP;
        return r;
    endfunction

    function automatic exp_t e_fetch();
        exp_t r = ex(FETCH);
        r.stb.ir_load = 1'b1;
        r.stb.pc_inc  = 1'b1;
        return r;
    endfunction

    function automatic exp_t e_op(input ctrl_state_t s, input logic op2);
        exp_t r = ex(s);
        r.stb.pc_inc = 1'b1;
        if (op2) r.stb.op2_load = 1'b1;
        else     r.stb.op1_load = 1'b1;
        return r;
    endfunction

    function automatic exp_t e_ctrl(input ctrl_state_t s, input ctrl_mux_A_t a,
                                    input ctrl_mux_B_t b, input reg_id_t idx,
                                    input alu_op_t alu);
        exp_t r = ex(s);
        r.own = FROM_CTRL;
        r.mem = ALU_ADDRESS;
        r.a   = a;
        r.b   = b;
        r.idx = idx;
        r.alu = alu;
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exv);
        n_asserts++;
        assert (obs === exv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
        end
    endtask

    task automatic check_pop();
        exp_t x;
        ctrl_strobe_t o;
        if (q.size() == 0) begin
            cmp("scoreboard_empty", 16'(q.size()), 16'd1);
            return;
        end
        x = q.pop_front();
        o.ir_load     = bus.ir_load_o;
        o.pc_inc      = bus.pc_inc_o;
        o.op1_load    = bus.op1_load_o;
        o.op2_load    = bus.op2_load_o;
        o.ptr_lo_load = bus.ptr_lo_load_o;
        o.reg_we      = bus.reg_we_o;
        o.mem_we      = bus.mem_we_o;
        o.done        = bus.instr_done_o;
        o.illegal     = bus.illegal_o;
        cmp("state",    16'(bus.state_o),        16'(x.st));
        cmp("strobes",  16'(o),                  16'(x.stb));
        cmp("mem_addr", 16'(bus.mux_mem_addr_o), 16'(x.mem));
        cmp("dec_ctrl", 16'(bus.mux_dec_ctrl_o), 16'(x.own));
        cmp("mux_A",    16'(bus.mux_A_o),        16'(x.a));
        cmp("mux_B",    16'(bus.mux_B_o),        16'(x.b));
        cmp("idx_reg",  16'(bus.idx_reg_o),      16'(x.idx));
        cmp("alu_op",   16'(bus.alu_op_ovr_o),   16'(x.alu));
    endtask

    task automatic step(input exp_t ev, input addressing_mode_t m, input logic st,
                        input logic rwe, input logic rdy, input logic rst);
        @(negedge clk);
        rst_i              = rst;
        bus.mem_rdy_i      = rdy;
        bus.dec_mode_i     = m;
        bus.dec_is_store_i = st;
        bus.dec_reg_we_i   = rwe;
        q.push_back(ev);
        #2;
        check_pop();
    endtask

    initial begin
        bus.mem_rdy_i      = 1'b1;
        bus.dec_mode_i     = IMPLIED;
        bus.dec_is_store_i = 1'b0;
        bus.dec_reg_we_i   = 1'b0;

        // Reset: defaults everywhere, even with ready and a reg-writing decode
        step(ex(FETCH), IMPLIED, 1'b0, 1'b1, 1'b1, 1'b1);
        step(ex(FETCH), IMPLIED, 1'b0, 1'b1, 1'b1, 1'b1);

        // LDA #$05
        step(e_fetch(), IMMEDIATE, 1'b0, 1'b1, 1'b1, 1'b0);
        e = ex(EX_FOP1); e.stb.pc_inc = 1; e.stb.reg_we = 1; e.stb.done = 1; e.a = IMMEDIATE_SRC;
        step(e, IMMEDIATE, 1'b0, 1'b1, 1'b1, 1'b0);

        // ORA $1234,X
        step(e_fetch(), ABSOLUTE_X, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), ABSOLUTE_X, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_op(FOP2, 1'b1), ABSOLUTE_X, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(EX_ABS, DATA_FROM_MEMORY_SRC, IDX_REG_SRC, X_REG, ALU_ADD);
        e.stb.reg_we = 1; e.stb.done = 1;
        step(e, ABSOLUTE_X, 1'b0, 1'b1, 1'b1, 1'b0);

        // STA ($40),Y
        step(e_fetch(), INDIRECT_Y, 1'b1, 1'b0, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), INDIRECT_Y, 1'b1, 1'b0, 1'b1, 1'b0);
        e = e_ctrl(FOP2, OPERAND_SRC, ZERO_SRC, A_REG, ALU_ADD_ZEROPAGE); e.stb.ptr_lo_load = 1;
        step(e, INDIRECT_Y, 1'b1, 1'b0, 1'b1, 1'b0);
        e = e_ctrl(EX_IND, PTR_ADDR_SRC, ONE_SRC, A_REG, ALU_ADD_ZEROPAGE); e.stb.op2_load = 1;
        step(e, INDIRECT_Y, 1'b1, 1'b0, 1'b1, 1'b0);
        e = e_ctrl(EX_ABS, OPERAND_SRC, IDX_REG_SRC, Y_REG, ALU_ADD);
        e.stb.mem_we = 1; e.stb.done = 1;
        step(e, INDIRECT_Y, 1'b1, 1'b0, 1'b1, 1'b0);

        // LDA ($20,X): pointer indexed by X, final address not indexed
        step(e_fetch(), INDIRECT_X, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), INDIRECT_X, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(FOP2, OPERAND_SRC, IDX_REG_SRC, X_REG, ALU_ADD_ZEROPAGE); e.stb.ptr_lo_load = 1;
        step(e, INDIRECT_X, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(EX_IND, PTR_ADDR_SRC, ONE_SRC, A_REG, ALU_ADD_ZEROPAGE); e.stb.op2_load = 1;
        step(e, INDIRECT_X, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(EX_ABS, DATA_FROM_MEMORY_SRC, ZERO_SRC, A_REG, ALU_ADD);
        e.stb.reg_we = 1; e.stb.done = 1;
        step(e, INDIRECT_X, 1'b0, 1'b1, 1'b1, 1'b0);

        // LDA $FF,X: zero-page wrap add
        step(e_fetch(), ZERO_PAGE_X, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), ZERO_PAGE_X, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(EX_ABS, DATA_FROM_MEMORY_SRC, IDX_REG_SRC, X_REG, ALU_ADD_ZEROPAGE);
        e.stb.reg_we = 1; e.stb.done = 1;
        step(e, ZERO_PAGE_X, 1'b0, 1'b1, 1'b1, 1'b0);

        // LDA $1234 with three wait cycles in FOP2
        step(e_fetch(), ABSOLUTE, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), ABSOLUTE, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(ex(FOP2), ABSOLUTE, 1'b0, 1'b1, 1'b0, 1'b0);
        step(e_op(FOP2, 1'b1), ABSOLUTE, 1'b0, 1'b1, 1'b1, 1'b0);
        e = e_ctrl(EX_ABS, DATA_FROM_MEMORY_SRC, ZERO_SRC, A_REG, ALU_ADD);
        e.stb.reg_we = 1; e.stb.done = 1;
        step(e, ABSOLUTE, 1'b0, 1'b1, 1'b1, 1'b0);

        // STA $10 interrupted by reset in EX_ABS
        step(e_fetch(), ZERO_PAGE, 1'b1, 1'b0, 1'b1, 1'b0);
        step(e_op(EX_FOP1, 1'b0), ZERO_PAGE, 1'b1, 1'b0, 1'b1, 1'b0);
        step(ex(EX_ABS), ZERO_PAGE, 1'b1, 1'b0, 1'b1, 1'b1);

        // JMP ($xxxx) is unsupported
        step(e_fetch(), ABSOLUTE_INDIRECT, 1'b0, 1'b0, 1'b1, 1'b0);
        e = ex(EX_FOP1); e.stb.illegal = 1; e.stb.done = 1;
        step(e, ABSOLUTE_INDIRECT, 1'b0, 1'b0, 1'b1, 1'b0);

        // TAX: implied register write, no PC increment
        step(e_fetch(), IMPLIED, 1'b0, 1'b1, 1'b1, 1'b0);
        e = ex(EX_FOP1); e.stb.reg_we = 1; e.stb.done = 1;
        step(e, IMPLIED, 1'b0, 1'b1, 1'b1, 1'b0);
        step(e_fetch(), IMPLIED, 1'b0, 1'b1, 1'b1, 1'b0);

        cmp("scoreboard_drained", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control FSM for the 6502 core. Each cycle it sequences instruction fetch, operand fetch, address generation and execute over the single shared memory port and ALU. It drives the ALU-operand, memory-address and decoder/control-override muxes, plus the load enables of the PC, the instruction register and the operand registers. It sits between the decoder (opcode -> addressing mode, ALU op, register write, store) and the datapath.

Parameters:
MEM_STALL_EN, 1, 1 = honour mem_rdy_i; 0 = treat mem_rdy_i as constantly 1.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous, active-high reset
mem_rdy_i  in  1  memory port completes the access this cycle
dec_mode_i  in  addressing_mode_t  addressing mode of the latched opcode
dec_is_store_i  in  1  instruction writes memory (STA/STX/STY)
dec_reg_we_i  in  1  instruction writes a register at execute
state_o  out  ctrl_state_t  current state
ir_load_o  out  1  latch opcode from memory data
pc_inc_o  out  1  PC <= PC+1
op1_load_o  out  1  latch operand byte 1 (low / zero-page)
op2_load_o  out  1  latch operand byte 2 (high / pointer high)
ptr_lo_load_o  out  1  latch indirect pointer low byte
mux_mem_addr_o  out  ctrl_mux_mem_addr_t  memory address source
mux_dec_ctrl_o  out  ctrl_mux_dec_ctrl_t  ALU operand-mux ownership
mux_A_o  out  ctrl_mux_A_t  ALU A select when FROM_CTRL
mux_B_o  out  ctrl_mux_B_t  ALU B select when FROM_CTRL
idx_reg_o  out  reg_id_t  index register (X_REG/Y_REG) read on B
alu_op_ovr_o  out  alu_op_t  ALU op when FROM_CTRL
reg_we_o  out  1  register-file write strobe
mem_we_o  out  1  memory write strobe
instr_done_o  out  1  one-cycle pulse on the final cycle of an instruction
illegal_o  out  1  one-cycle pulse for an unsupported mode

Behaviour:
- State register of type ctrl_state_t. Reset: state FETCH. While rst_i=1, all strobes/enables = 0, mux_mem_addr_o = PC_FETCH_ADDRESS, mux_dec_ctrl_o = FROM_DECODER, alu_op_ovr_o = ALU_NOP.
- Outputs are combinational from the state and inputs.
- Every strobe (ir/pc/op/ptr loads, reg_we, mem_we, done, illegal) is ANDed with mem_rdy_i. A state advances only when mem_rdy_i=1; otherwise it holds and all muxes stay stable.
- FETCH: addr = PC, ir_load_o = 1, pc_inc_o = 1, next = EX_FOP1.
- EX_FOP1, per dec_mode_i:
  - IMPLIED/ACCUMULATOR: execute; reg_we_o = dec_reg_we_i; done; next FETCH; no pc_inc.
  - IMMEDIATE/RELATIVE: addr = PC, pc_inc_o = 1, mux_A IMMEDIATE_SRC; execute; done; next FETCH.
  - ZERO_PAGE*: op1_load_o, pc_inc_o; next EX_ABS.
  - ABSOLUTE*: op1_load_o, pc_inc_o; next FOP2.
  - INDIRECT_X/Y: op1_load_o, pc_inc_o; next FOP2.
  - ABSOLUTE_INDIRECT or any other value: illegal_o = 1, done; next FETCH.
- FOP2:
  - ABSOLUTE*: addr = PC, op2_load_o, pc_inc_o; next EX_ABS.
  - INDIRECT_X: FROM_CTRL, alu_op ALU_ADD_ZEROPAGE (op1 + X, wraps mod 256), addr = ALU_ADDRESS, ptr_lo_load_o; next EX_IND.
  - INDIRECT_Y: as INDIRECT_X with B = ZERO_SRC; next EX_IND.
- EX_IND: pointer-high read at (pointer address + 1) mod 256, computed via ALU_ADD_ZEROPAGE. op2_load_o; next EX_ABS.
- EX_ABS: addr = ALU_ADDRESS, FROM_CTRL.
  - Index select: ZERO_PAGE_X/ABSOLUTE_X -> X_REG; ZERO_PAGE_Y/ABSOLUTE_Y/INDIRECT_Y -> Y_REG; else ZERO_SRC.
  - ALU op: ALU_ADD_ZEROPAGE for zero-page modes (no carry into high byte); ALU_ADD otherwise (16-bit).
  - Store: mem_we_o = 1. Load/ALU: data routed via DATA_FROM_MEMORY_SRC; reg_we_o = dec_reg_we_i.
  - done; next FETCH.
- Cycle counts with mem_rdy_i=1: implied/immediate 2; zero page 3; absolute 4; indirect 5.
- Reset mid-instruction: next state is FETCH, and no write strobe asserts in the reset cycle.
- Undefined state encodings go to FETCH.

Decomposition:
- Shared package: ctrl_state_t, addressing_mode_t, alu_op_t, reg_id_t and the mux enums already live there.
- Add a CTRL_CYCLES_* constant per mode class for the bench.
- One natural sub-module, cpu_ctrl_addr_sel: combinational mode -> {idx_reg, mux_B, alu_op} mapping, shared by FOP2 and EX_ABS.

Test Plan:
- Reset then LDA #$05 (IMMEDIATE, reg_we=1): FETCH, EX_FOP1; ir_load, pc_inc x2, reg_we in cycle 2 with mux_A IMMEDIATE_SRC; instr_done on cycle 2.
- ORA $1234,X (ABSOLUTE_X): states FETCH, EX_FOP1, FOP2, EX_ABS; pc_inc x3; EX_ABS shows idx_reg X_REG, ALU_ADD, ALU_ADDRESS, reg_we=1.
- STA ($40),Y (INDIRECT_Y, store): 5 states ending in EX_IND, EX_ABS; ptr_lo_load in FOP2, op2_load in EX_IND, mem_we=1 only in EX_ABS, reg_we never set.
- LDA $FF,X (ZERO_PAGE_X): EX_ABS uses ALU_ADD_ZEROPAGE; 3 cycles total.
- mem_rdy_i low for 3 cycles during FOP2: state_o holds FOP2, all strobes 0; resumes and completes after 4 ready cycles.
- rst_i in EX_ABS of a store: mem_we_o=0 that cycle, next state FETCH. ABSOLUTE_INDIRECT mode: illegal_o pulse in cycle 2, return to FETCH.
